// File: rtl/obj_det_zone_monitor.sv
// Per-zone frame-difference detector: counts cur/ref mismatches in vertical strips, then
// evaluates each zone at frame end and tracks how long a detected object stays static.
module obj_det_zone_monitor #(
    parameter int FRAME_W   = 320,
    parameter int FRAME_H   = 240,
    parameter int NUM_ZONES = 4,
    parameter int CNT_W     = 17,
    parameter int SUSP_W    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ov7670_config_done,
    input  logic                        start_capture,
    input  logic                        pixel_valid,
    input  logic                        pixel_sof,
    input  logic                        cur_bit,
    input  logic                        ref_bit,
    input  logic [CNT_W-1:0]            detection_thres,
    input  logic [CNT_W-1:0]            static_thres,
    input  logic [SUSP_W-1:0]           suspicion_thres,
    output logic [NUM_ZONES-1:0]        zone_detected,
    output logic [NUM_ZONES-1:0]        zone_susp,
    output logic                        object_detected,
    output logic                        object_susp,
    output logic [NUM_ZONES*SUSP_W-1:0] suspicion_out,
    output logic                        frame_done,
    output logic                        overrun
);
    localparam int ZONE_W = FRAME_W / NUM_ZONES;
    localparam int TOTAL  = FRAME_W * FRAME_H;
    localparam int XW     = (FRAME_W > 1)   ? $clog2(FRAME_W)   : 1;
    localparam int ZXW    = (ZONE_W > 1)    ? $clog2(ZONE_W)    : 1;
    localparam int ZIW    = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;
    localparam int PW     = (TOTAL > 1)     ? $clog2(TOTAL)     : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_SOF, S_ACCUM} state_t;

    state_t                state_q, state_d;
    logic [XW-1:0]         x_q, x_d, cur_x;
    logic [ZXW-1:0]        zx_q, zx_d, cur_zx;
    logic [ZIW-1:0]        zone_q, zone_d, cur_zone;
    logic [PW-1:0]         pix_q, pix_d, cur_pix;
    logic [CNT_W-1:0]      live_q [NUM_ZONES];
    logic [CNT_W-1:0]      live_d [NUM_ZONES];
    logic [CNT_W-1:0]      snap_q [NUM_ZONES];
    logic [CNT_W-1:0]      snap_d [NUM_ZONES];
    logic [CNT_W-1:0]      prev_q [NUM_ZONES];
    logic [CNT_W-1:0]      prev_d [NUM_ZONES];
    logic [CNT_W-1:0]      lc     [NUM_ZONES];
    logic [SUSP_W-1:0]     susp_q [NUM_ZONES];
    logic [SUSP_W-1:0]     susp_d [NUM_ZONES];
    logic [NUM_ZONES-1:0]  zone_det_q, zone_det_d, zone_susp_q, zone_susp_d;
    logic                  obj_det_q, obj_det_d, obj_susp_q, obj_susp_d;
    logic                  eval_busy_q, eval_busy_d;
    logic [ZIW-1:0]        eval_zone_q, eval_zone_d;
    logic                  frame_done_q, frame_done_d, overrun_q, overrun_d;

    logic                  accept, restart, is_last;
    logic [CNT_W-1:0]      ev_d, ev_p;
    logic [CNT_W:0]        ev_diff;
    logic                  ev_det, ev_sta;
    logic [SUSP_W-1:0]     ev_susp;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        zx_d         = zx_q;
        zone_d       = zone_q;
        pix_d        = pix_q;
        live_d       = live_q;
        snap_d       = snap_q;
        prev_d       = prev_q;
        susp_d       = susp_q;
        lc           = live_q;
        zone_det_d   = zone_det_q;
        zone_susp_d  = zone_susp_q;
        obj_det_d    = |zone_det_q;
        obj_susp_d   = |zone_susp_q;
        eval_busy_d  = eval_busy_q;
        eval_zone_d  = eval_zone_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        ev_d         = '0;
        ev_p         = '0;
        ev_diff      = '0;
        ev_det       = 1'b0;
        ev_sta       = 1'b0;
        ev_susp      = '0;

        accept  = pixel_valid & (((state_q == S_WAIT_SOF) & pixel_sof) | (state_q == S_ACCUM));
        restart = accept & pixel_sof;
        cur_x    = restart ? '0 : x_q;
        cur_zx   = restart ? '0 : zx_q;
        cur_zone = restart ? '0 : zone_q;
        cur_pix  = restart ? '0 : pix_q;
        is_last  = (cur_pix == PW'(TOTAL - 1));

        if (state_q == S_IDLE && ov7670_config_done && start_capture)
            state_d = S_WAIT_SOF;

        // One zone per cycle; runs alongside accumulation of the following frame.
        if (eval_busy_q) begin
            ev_d    = snap_q[eval_zone_q];
            ev_p    = prev_q[eval_zone_q];
            ev_diff = (ev_d >= ev_p) ? ({1'b0, ev_d} - {1'b0, ev_p})
                                     : ({1'b0, ev_p} - {1'b0, ev_d});
            ev_det  = (ev_d >= detection_thres);
            ev_sta  = (ev_diff <= {1'b0, static_thres});
            if (ev_det && ev_sta)
                ev_susp = (susp_q[eval_zone_q] == '1) ? susp_q[eval_zone_q]
                                                      : susp_q[eval_zone_q] + SUSP_W'(1);
            susp_d[eval_zone_q]      = ev_susp;
            zone_det_d[eval_zone_q]  = ev_det;
            zone_susp_d[eval_zone_q] = (suspicion_thres != '0) && (ev_susp >= suspicion_thres);
            prev_d[eval_zone_q]      = ev_d;
            if (eval_zone_q == ZIW'(NUM_ZONES - 1)) begin
                eval_busy_d  = 1'b0;
                frame_done_d = 1'b1;
            end else begin
                eval_zone_d = eval_zone_q + ZIW'(1);
            end
        end

        if (accept) begin
            state_d = S_ACCUM;
            if (restart)
                for (int z = 0; z < NUM_ZONES; z++) lc[z] = '0;
            if ((cur_bit ^ ref_bit) && (lc[cur_zone] != '1))
                lc[cur_zone] = lc[cur_zone] + CNT_W'(1);
            if (cur_x == XW'(FRAME_W - 1)) begin
                x_d    = '0;
                zx_d   = '0;
                zone_d = '0;
            end else begin
                x_d = cur_x + XW'(1);
                if (cur_zx == ZXW'(ZONE_W - 1)) begin
                    zx_d   = '0;
                    zone_d = cur_zone + ZIW'(1);
                end else begin
                    zx_d   = cur_zx + ZXW'(1);
                    zone_d = cur_zone;
                end
            end
            if (is_last) begin
                pix_d = '0;
                for (int z = 0; z < NUM_ZONES; z++) live_d[z] = '0;
                if (eval_busy_q) begin
                    overrun_d = 1'b1;
                end else begin
                    snap_d      = lc;
                    eval_busy_d = 1'b1;
                    eval_zone_d = '0;
                end
            end else begin
                pix_d  = cur_pix + PW'(1);
                live_d = lc;
            end
        end

        if (!start_capture) begin
            state_d      = S_IDLE;
            x_d          = '0;
            zx_d         = '0;
            zone_d       = '0;
            pix_d        = '0;
            zone_det_d   = '0;
            zone_susp_d  = '0;
            obj_det_d    = 1'b0;
            obj_susp_d   = 1'b0;
            eval_busy_d  = 1'b0;
            eval_zone_d  = '0;
            frame_done_d = 1'b0;
            overrun_d    = 1'b0;
            for (int z = 0; z < NUM_ZONES; z++) begin
                live_d[z] = '0;
                snap_d[z] = '0;
                prev_d[z] = '0;
                susp_d[z] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            zx_q         <= '0;
            zone_q       <= '0;
            pix_q        <= '0;
            zone_det_q   <= '0;
            zone_susp_q  <= '0;
            obj_det_q    <= 1'b0;
            obj_susp_q   <= 1'b0;
            eval_busy_q  <= 1'b0;
            eval_zone_q  <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            for (int z = 0; z < NUM_ZONES; z++) begin
                live_q[z] <= '0;
                snap_q[z] <= '0;
                prev_q[z] <= '0;
                susp_q[z] <= '0;
            end
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            zx_q         <= zx_d;
            zone_q       <= zone_d;
            pix_q        <= pix_d;
            zone_det_q   <= zone_det_d;
            zone_susp_q  <= zone_susp_d;
            obj_det_q    <= obj_det_d;
            obj_susp_q   <= obj_susp_d;
            eval_busy_q  <= eval_busy_d;
            eval_zone_q  <= eval_zone_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            live_q       <= live_d;
            snap_q       <= snap_d;
            prev_q       <= prev_d;
            susp_q       <= susp_d;
        end
    end

    always_comb begin
        suspicion_out = '0;
        for (int z = 0; z < NUM_ZONES; z++)
            suspicion_out[z*SUSP_W +: SUSP_W] = susp_q[z];
    end

    assign zone_detected   = zone_det_q;
    assign zone_susp       = zone_susp_q;
    assign object_detected = obj_det_q;
    assign object_susp     = obj_susp_q;
    assign frame_done      = frame_done_q;
    assign overrun         = overrun_q;
endmodule

// File: tb/tb_obj_det_zone_monitor.sv
// Directed bench: 8x2 frames in 4 zones of 2 pixels; zone 1 covers pixels 2,3,10,11.
module tb_obj_det_zone_monitor;
    logic       clk = 1'b0;
    logic       reset;
    logic       ov7670_config_done, start_capture;
    logic       pixel_valid, pixel_sof, cur_bit, ref_bit;
    logic [7:0] detection_thres, static_thres;
    logic [1:0] suspicion_thres;
    logic [3:0] zone_detected, zone_susp;
    logic       object_detected, object_susp, frame_done, overrun;
    logic [7:0] suspicion_out;

    int total = 0;
    int bad   = 0;
    int fd_cnt = 0;

    localparam logic [15:0] MA = 16'h0C0C; // zone 1: 4 diff pixels
    localparam logic [15:0] MB = 16'h040C; // zone 1: 3 diff pixels

    obj_det_zone_monitor #(
        .FRAME_W(8), .FRAME_H(2), .NUM_ZONES(4), .CNT_W(8), .SUSP_W(2)
    ) dut (
        .clk(clk), .reset(reset), .ov7670_config_done(ov7670_config_done),
        .start_capture(start_capture), .pixel_valid(pixel_valid), .pixel_sof(pixel_sof),
        .cur_bit(cur_bit), .ref_bit(ref_bit), .detection_thres(detection_thres),
        .static_thres(static_thres), .suspicion_thres(suspicion_thres),
        .zone_detected(zone_detected), .zone_susp(zone_susp),
        .object_detected(object_detected), .object_susp(object_susp),
        .suspicion_out(suspicion_out), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done) fd_cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_pix(input bit sof, input bit diff);
        pixel_valid = 1'b1;
        pixel_sof   = sof;
        ref_bit     = 1'($urandom_range(0, 1));
        cur_bit     = ref_bit ^ diff;
        @(posedge clk); #1;
        pixel_valid = 1'b0;
        pixel_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] m);
        for (int i = 0; i < 16; i++) send_pix(i == 0, m[i]);
    endtask

    task automatic check_zero(input string tag);
        chk(tag, {zone_detected, zone_susp, suspicion_out, object_detected, object_susp,
                  frame_done, overrun}, 32'h0);
    endtask

    task automatic run_frame(input string tag, input logic [15:0] m, input logic [3:0] e_det,
                             input logic [1:0] e_s1, input logic [3:0] e_zs);
        send_frame(m);
        idle(3);
        chk({tag, ".fd_early"}, frame_done, 0);
        idle(1);
        chk({tag, ".fd"}, frame_done, 1);
        chk({tag, ".det"}, zone_detected, e_det);
        chk({tag, ".susp"}, suspicion_out, {26'd0, e_s1, 2'b00});
        chk({tag, ".zsusp"}, zone_susp, e_zs);
        idle(1);
        chk({tag, ".fd_end"}, frame_done, 0);
        chk({tag, ".objdet"}, object_detected, |e_det);
        chk({tag, ".objsusp"}, object_susp, |e_zs);
        chk({tag, ".ovr"}, overrun, 0);
    endtask

    initial begin
        reset = 1'b1; ov7670_config_done = 1'b0; start_capture = 1'b0;
        pixel_valid = 1'b0; pixel_sof = 1'b0; cur_bit = 1'b0; ref_bit = 1'b0;
        detection_thres = 8'd3; static_thres = 8'd0; suspicion_thres = 2'd3;
        idle(2);
        check_zero("reset");
        reset = 1'b0;
        start_capture = 1'b1;
        idle(2);
        // Without config_done a full frame must be ignored.
        send_frame(MA);
        idle(6);
        chk("no_cfg_fd", fd_cnt, 0);
        ov7670_config_done = 1'b1;
        idle(2);

        run_frame("f1", MA, 4'b0010, 2'd0, 4'b0000);
        run_frame("f2", MA, 4'b0010, 2'd1, 4'b0000);
        run_frame("f3", MA, 4'b0010, 2'd2, 4'b0000);
        run_frame("f4", MA, 4'b0010, 2'd3, 4'b0010);
        run_frame("f5", MB, 4'b0010, 2'd0, 4'b0000);
        run_frame("f6", MA, 4'b0010, 2'd0, 4'b0000);
        static_thres = 8'd1;
        run_frame("f7", MB, 4'b0010, 2'd1, 4'b0000);
        run_frame("f8", MA, 4'b0010, 2'd2, 4'b0000);
        run_frame("f9", MB, 4'b0010, 2'd3, 4'b0010);
        run_frame("f10", MA, 4'b0010, 2'd3, 4'b0010);
        run_frame("f11", MA, 4'b0010, 2'd3, 4'b0010);
        detection_thres = 8'd4;
        run_frame("f12", MB, 4'b0000, 2'd0, 4'b0000);

        // Partial frame restarted by a new sof: only the full frame is evaluated.
        for (int i = 0; i < 5; i++) send_pix(i == 0, MA[i]);
        idle(3);
        run_frame("sof", MA, 4'b0010, 2'd1, 4'b0000);
        chk("fd_count_a", fd_cnt, 13);

        // Drop start_capture in the middle of EVAL.
        send_frame(MA);
        idle(2);
        start_capture = 1'b0;
        idle(1);
        check_zero("stop_eval");
        idle(4);
        check_zero("stop_hold");
        start_capture = 1'b1;
        idle(2);
        for (int i = 0; i < 16; i++) send_pix(1'b0, MA[i]);
        idle(8);
        chk("fd_count_b", fd_cnt, 13);
        run_frame("restart", MA, 4'b0010, 2'd0, 4'b0000);

        // Async reset mid-accumulation.
        for (int i = 0; i < 8; i++) send_pix(i == 0, MA[i]);
        reset = 1'b1;
        #1;
        check_zero("reset_mid");
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);
        run_frame("post_rst", MA, 4'b0010, 2'd0, 4'b0000);
        chk("fd_count_c", fd_cnt, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
